// File: rtl/seg_pkg.sv
// Shared constants for the multi-digit seven-segment driver: blank code and
// the active-low hex decode table (bit 0 = segment a .. bit 6 = segment g).
package seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Entry n is the active-low pattern for hex digit n.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46,  // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,  // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,  // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40   // 3 2 1 0
  };

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-low seven-segment decode.
module hex_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[hex];

endmodule

// File: rtl/seg_display_multi.sv
// Multi-digit hex display driver: shadow capture, leading-zero blanking,
// per-digit blink and PWM brightness, one register stage on the segment outputs.
module seg_display_multi
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int BLINK_DIV  = 25000000,
  parameter int PWM_BITS   = 4
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    load,
  input  logic                    hold,
  input  logic                    blank_lz,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic [PWM_BITS-1:0]     brightness,
  output logic [7*NUM_DIGITS-1:0] seg,
  output logic                    loaded
);

  localparam int PRE_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(BLINK_DIV - 1);

  logic [4*NUM_DIGITS-1:0]      shadow;
  logic                         valid;
  logic [PRE_W-1:0]             prescaler;
  logic                         blink_phase;
  logic [PWM_BITS-1:0]          pwm_cnt;
  logic [NUM_DIGITS-1:0][6:0]   dec;
  logic [NUM_DIGITS-1:0]        lz_mask;
  logic                         all_zero;
  logic                         pwm_on;
  logic                         accept;
  logic [7*NUM_DIGITS-1:0]      seg_next;

  // Handshake: load is a one-cycle strobe with no back-pressure; an edge with
  // load=1 and hold=0 is accepted, and loaded acknowledges it for exactly the
  // following cycle. hold=1 silently drops the strobe.
  assign accept = load && !hold;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      shadow <= '0;
      valid  <= 1'b0;
      loaded <= 1'b0;
    end else begin
      loaded <= accept;
      if (accept) begin
        shadow <= value;
        valid  <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      prescaler   <= '0;
      blink_phase <= 1'b0;
      pwm_cnt     <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      if (prescaler == PRE_MAX) begin
        prescaler   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        prescaler <= prescaler + 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
    hex_to_seg u_hex_to_seg (
      .hex (shadow[4*g +: 4]),
      .seg (dec[g])
    );
  end

  // Scan from the most significant digit down; digit 0 never takes part.
  always_comb begin
    all_zero = 1'b1;
    lz_mask  = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      all_zero   = all_zero && (shadow[4*i +: 4] == 4'h0);
      lz_mask[i] = blank_lz && all_zero;
    end
  end

  assign pwm_on = (brightness > pwm_cnt);

  always_comb begin
    seg_next = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!valid || lz_mask[i] || (blink_phase && blink_mask[i]) || !pwm_on) begin
        seg_next[7*i +: 7] = SEG_BLANK;
      end else begin
        seg_next[7*i +: 7] = dec[i];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      seg <= '1;
    end else begin
      seg <= seg_next;
    end
  end

endmodule

// File: tb/tb_seg_display_multi.sv
// Directed bench for seg_display_multi (6 digits, BLINK_DIV=4, PWM_BITS=4):
// decode/blanking table plus hold, back-to-back, blink, PWM and reset sequences.
module tb_seg_display_multi;

  localparam int N = 6;
  localparam logic [41:0] ONES = '1;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic [23:0] value = '0;
  logic        load = 1'b0;
  logic        hold = 1'b0;
  logic        blank_lz = 1'b0;
  logic [5:0]  blink_mask = '0;
  logic [3:0]  brightness = 4'hF;
  logic [41:0] seg;
  logic        loaded;

  int vectors = 0;
  int miscompares = 0;

  seg_display_multi #(
    .NUM_DIGITS (N),
    .BLINK_DIV  (4),
    .PWM_BITS   (4)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .value      (value),
    .load       (load),
    .hold       (hold),
    .blank_lz   (blank_lz),
    .blink_mask (blink_mask),
    .brightness (brightness),
    .seg        (seg),
    .loaded     (loaded)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Free-running counter model; u_* hold the values in force when the
  // currently visible seg word was computed.
  logic [3:0] m_pwm, u_pwm;
  logic [1:0] m_pre;
  logic       m_phase, u_phase;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_pwm <= '0; u_pwm <= '0; m_pre <= '0; m_phase <= 1'b0; u_phase <= 1'b0;
    end else begin
      u_pwm   <= m_pwm;
      u_phase <= m_phase;
      m_pwm   <= m_pwm + 4'd1;
      if (m_pre == 2'd3) begin
        m_pre   <= '0;
        m_phase <= ~m_phase;
      end else begin
        m_pre <= m_pre + 2'd1;
      end
    end
  end

  typedef struct {
    logic [23:0] value;
    logic        blz;
    logic [41:0] exp;
  } vec_t;

  vec_t vecs[10];

  // Scoreboard
  task automatic check(input string name, input logic [41:0] act, input logic [41:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [41:0] pwm_gate(input logic [41:0] e);
    return (u_pwm < brightness) ? e : ONES;
  endfunction

  task automatic wait_lit;
    for (int k = 0; k < 4; k++) begin
      if (u_pwm < brightness) return;
      step();
    end
    vectors++;
    miscompares++;
    $display("FAIL wait_lit: pwm window never opened, pwm=%0d brightness=%0d", u_pwm, brightness);
  endtask

  task automatic do_load(input logic [23:0] v, input logic blz, input logic [41:0] exp,
                         input string name);
    value    = v;
    blank_lz = blz;
    load     = 1'b1;
    step();
    load = 1'b0;
    check({name, " loaded"}, {41'b0, loaded}, 42'd1);
    step();
    check({name, " loaded_drop"}, {41'b0, loaded}, 42'd0);
    wait_lit();
    check({name, " seg"}, seg, exp);
  endtask

  localparam logic [41:0] E123 = {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02};
  localparam logic [41:0] E0A3 = {7'h40, 7'h40, 7'h08, 7'h30, 7'h0E, 7'h40};

  initial begin
    logic [41:0] e;
    int lit0, lit5;

    vecs[0] = '{24'h00A3F0, 1'b0, E0A3};
    vecs[1] = '{24'h00A3F0, 1'b1, {7'h7F, 7'h7F, 7'h08, 7'h30, 7'h0E, 7'h40}};
    vecs[2] = '{24'h000000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}};
    vecs[3] = '{24'h000000, 1'b0, {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}};
    vecs[4] = '{24'h123456, 1'b0, E123};
    vecs[5] = '{24'h789ABC, 1'b1, {7'h78, 7'h00, 7'h10, 7'h08, 7'h03, 7'h46}};
    vecs[6] = '{24'hDEF000, 1'b1, {7'h21, 7'h06, 7'h0E, 7'h40, 7'h40, 7'h40}};
    vecs[7] = '{24'h000100, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h40, 7'h40}};
    vecs[8] = '{24'h010000, 1'b1, {7'h7F, 7'h79, 7'h40, 7'h40, 7'h40, 7'h40}};
    vecs[9] = '{24'h00000F, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h0E}};

    // Reset state
    #2 resetn = 1'b0;
    #1;
    check("reset seg", seg, ONES);
    check("reset loaded", {41'b0, loaded}, 42'd0);
    step();
    check("reset held seg", seg, ONES);
    @(negedge clk) resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("invalid blank", seg, ONES);
      check("idle loaded", {41'b0, loaded}, 42'd0);
    end

    // Decode and leading-zero table
    for (int i = 0; i < 10; i++) begin
      do_load(vecs[i].value, vecs[i].blz, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // blank_lz toggled without load takes effect on the next edge
    blank_lz = 1'b0;
    step();
    wait_lit();
    check("lz off live", seg, {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h0E});

    // Hold wins over load
    value = 24'h123456; hold = 1'b1; load = 1'b1;
    step();
    check("hold loaded", {41'b0, loaded}, 42'd0);
    load = 1'b0; hold = 1'b0;
    step();
    wait_lit();
    check("hold seg", seg, {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h0E});
    do_load(24'h123456, 1'b0, E123, "after_hold");

    // Back-to-back loads, last one wins
    value = 24'h111111; load = 1'b1;
    step();
    check("b2b loaded1", {41'b0, loaded}, 42'd1);
    value = 24'h222222;
    step();
    check("b2b loaded2", {41'b0, loaded}, 42'd1);
    check("b2b seg1", seg, pwm_gate({6{7'h79}}));
    load = 1'b0;
    step();
    check("b2b seg2", seg, pwm_gate({6{7'h24}}));
    check("b2b loaded_drop", {41'b0, loaded}, 42'd0);

    // Blink on digit 0 only
    do_load(24'h123456, 1'b0, E123, "blink_setup");
    blink_mask = 6'b000001;
    for (int i = 0; i < 24; i++) begin
      step();
      e = E123;
      if (u_phase) e[6:0] = 7'h7F;
      check($sformatf("blink c%0d", i), seg, pwm_gate(e));
    end
    blink_mask = '0;

    // PWM duty: brightness=4 lights each digit 4 of 16 cycles
    brightness = 4'd4;
    lit0 = 0;
    lit5 = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      check($sformatf("pwm4 c%0d", i), seg, pwm_gate(E123));
      if (seg[6:0] != 7'h7F) lit0++;
      if (seg[41:35] != 7'h7F) lit5++;
    end
    check("pwm4 lit digit0", 42'(lit0), 42'd4);
    check("pwm4 lit digit5", 42'(lit5), 42'd4);

    brightness = 4'd0;
    for (int i = 0; i < 16; i++) begin
      step();
      check($sformatf("pwm0 c%0d", i), seg, ONES);
    end
    brightness = 4'hF;

    // Asynchronous reset mid-display
    step();
    wait_lit();
    check("pre-reset seg", seg, E123);
    #2 resetn = 1'b0;
    #1;
    check("async reset seg", seg, ONES);
    check("async reset loaded", {41'b0, loaded}, 42'd0);
    step();
    check("reset cycle seg", seg, ONES);
    @(negedge clk) resetn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check("post-reset blank", seg, ONES);
    end
    do_load(24'h00A3F0, 1'b0, E0A3, "post_reset");

    // Final report
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/seg_display_multi.md
SEG_DISPLAY_MULTI -- requirements
Module: seg_display_multi

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 6, meaning the number of hex digits driven (legal range 1..8).
REQ-002 SHALL have parameter BLINK_DIV, default 25000000, meaning clk cycles per blink half-period (legal minimum 2).
REQ-003 SHALL have parameter PWM_BITS, default 4, meaning the brightness resolution in bits.
REQ-004 SHALL have port: clk  input  1  system clock; one clock only, all state on its rising edge.
REQ-005 SHALL have port: resetn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port: value  input  4*NUM_DIGITS  hex value; digit i = value[4i+3:4i].
REQ-007 SHALL have port: load  input  1  single-cycle capture strobe.
REQ-008 SHALL have port: hold  input  1  freeze; while high, load is ignored.
REQ-009 SHALL have port: blank_lz  input  1  leading-zero blanking enable.
REQ-010 SHALL have port: blink_mask  input  NUM_DIGITS  per-digit blink enable.
REQ-011 SHALL have port: brightness  input  PWM_BITS  display duty.
REQ-012 SHALL have port: seg  output  7*NUM_DIGITS  registered, active-low segments; digit i = seg[7i+6:7i], bit 0 = a through bit 6 = g.
REQ-013 SHALL have port: loaded  output  1  one-cycle pulse marking an accepted load.

Function
REQ-014 On a rising clk edge with load=1 and hold=0, the module SHALL copy value into a shadow register and set an internal valid flag.
REQ-015 If load=1 and hold=1 on the same edge, hold SHALL win: the shadow register is unchanged and loaded is not pulsed.
REQ-016 loaded SHALL be high for exactly the one cycle after an accepted load edge.
REQ-017 seg SHALL reflect a newly loaded value 2 cycles after the load edge (shadow register, then seg register).
REQ-018 Back-to-back loads on consecutive edges SHALL each be accepted; the last one wins.
REQ-019 While valid=0, every digit SHALL output SEG_BLANK (7'h7F).
REQ-020 Decode SHALL be: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E (hex, active-low).
REQ-021 With blank_lz=1, digit i (i>=1) SHALL be blanked when digits i..NUM_DIGITS-1 are all zero; digit 0 is never blanked by this rule.
REQ-022 The blink prescaler SHALL count 0..BLINK_DIV-1 and wrap to 0; each wrap SHALL toggle blink_phase.
REQ-023 When blink_phase=1, every digit whose blink_mask bit is 1 SHALL be blanked.
REQ-024 The PWM counter SHALL be free-running at PWM_BITS width and wrap naturally.
REQ-025 A digit's segments SHALL be lit only while brightness > pwm_cnt; otherwise that digit is blank.
  - brightness=0 gives a permanently dark display.
  - brightness=all-ones gives a (2^PWM_BITS-1)/2^PWM_BITS duty.
REQ-026 Blank precedence SHALL be: !valid, then leading-zero, then blink, then PWM. Any active blank source forces 7'h7F.
REQ-027 Changes on blank_lz, blink_mask and brightness SHALL take effect on seg 1 cycle later; they do not need load.

Reset
REQ-028 While resetn=0, asynchronously: seg=all ones, loaded=0, shadow=0, valid=0, prescaler=0, blink_phase=0, pwm_cnt=0.
REQ-029 Reset asserted mid-operation SHALL discard the shadow value; after release the display stays blank until the next accepted load.
REQ-030 The counters SHALL start counting on the first edge after resetn deasserts.

Structure
REQ-031 Package seg_pkg SHALL hold SEG_BLANK (7'h7F) and the 16-entry decode table of REQ-020.
REQ-032 A combinational sub-module hex_to_seg (4-bit in, 7-bit active-low out) SHALL be instantiated NUM_DIGITS times via generate.
REQ-033 All blanking and PWM logic SHALL be in seg_display_multi, with a single register stage on seg.

Verification
REQ-034 Reset, then load value=24'h00A3F0 with blank_lz=0 and brightness=F -> loaded pulses 1 cycle later; 2 cycles after load, seg digits 5..0 = 40,40,08,30,0E,40 whenever pwm_cnt<F.
REQ-035 Same value with blank_lz=1 -> digits 5,4 = 7F; digits 3..0 unchanged; value=0 -> only digit 0 shows 40.
REQ-036 Hold=1 with load=1 and value=24'h123456 -> display unchanged and no loaded pulse; then hold=0 with load -> 123456 appears 2 cycles later.
REQ-037 BLINK_DIV=4 and blink_mask=6'b000001 -> digit 0 alternates visible/7F every 4 cycles; other digits remain steady.
REQ-038 brightness=4 with PWM_BITS=4 -> each digit is lit exactly 4 of every 16 cycles; brightness=0 -> seg stays all ones.
REQ-039 Assert resetn=0 for 1 cycle mid-display -> seg goes all ones immediately (asynchronously) and stays blank until the next load.
